// File: rtl/gs_pkg.sv
// Shared constants and state encoding for the Goldschmidt divider path.
package gs_pkg;

  // Q-format constants
  localparam int unsigned MANT_W = 24;
  localparam int unsigned FRAC_W = 23;
  localparam logic [MANT_W:0] TWO_Q = 25'h1000000;

  // Slice of the Q2.46 product that forms the next Q1.23 value
  localparam int unsigned PROD_W  = 2 * MANT_W;
  localparam int unsigned PROD_HI = 46;
  localparam int unsigned PROD_LO = 23;

  // Sequencer states
  typedef logic [2:0] gs_state_t;
  localparam gs_state_t StIdle   = 3'd0;
  localparam gs_state_t StIssueN = 3'd1;
  localparam gs_state_t StIssueD = 3'd2;
  localparam gs_state_t StWait   = 3'd3;
  localparam gs_state_t StDone   = 3'd4;

endpackage

// File: rtl/gs_iter_ctrl_if.sv
// Request/response handshake plus multiplier loop for the Goldschmidt sequencer.
interface gs_iter_ctrl_if;
  import gs_pkg::*;

  logic                start;
  logic [MANT_W-1:0]   n_in;
  logic [MANT_W-1:0]   d_in;
  logic [PROD_W-1:0]   product;
  logic [31:0]         mul_a;
  logic [31:0]         mul_b;
  logic                mul_en;
  logic                busy;
  logic                done;
  logic [MANT_W-1:0]   q_out;
  logic                err;

  // Sequencer side
  modport slave (
    input  start, n_in, d_in, product,
    output mul_a, mul_b, mul_en, busy, done, q_out, err
  );

  // Requester / multiplier side
  modport master (
    output start, n_in, d_in, product,
    input  mul_a, mul_b, mul_en, busy, done, q_out, err
  );

endinterface

// File: rtl/gs_factor_gen.sv
// Goldschmidt factor F = 2 - D in Q1.23, truncated to the mantissa width.
module gs_factor_gen
  import gs_pkg::*;
(
  input  logic [MANT_W-1:0] d_i,
  output logic [MANT_W-1:0] f_o
);

  // D in [0.5,1) keeps F in (1,1.5], so dropping the carry bit is lossless
  assign f_o = MANT_W'(TWO_Q - {1'b0, d_i});

endmodule

// File: rtl/gs_iter_ctrl.sv
// Goldschmidt iteration sequencer: issues N*F / D*F pairs to an external
// pipelined multiplier and folds the returned products back into N, D and F.
module gs_iter_ctrl
  import gs_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned ITERS   = 5
) (
  input logic           clk,
  input logic           clear,
  gs_iter_ctrl_if.slave bus
);

  localparam int unsigned WaitW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int unsigned IterW = $clog2(ITERS + 1);

  gs_state_t         state_q, state_d;
  logic [MANT_W-1:0] n_q, n_d;
  logic [MANT_W-1:0] d_q, d_d;
  logic [MANT_W-1:0] f_q, f_d;
  logic [MANT_W-1:0] q_q, q_d;
  logic              err_q, err_d;
  logic [IterW-1:0]  iter_q, iter_d, iter_inc;
  logic [WaitW-1:0]  wait_q, wait_d;

  logic [MANT_W-1:0] prod_val;
  logic [MANT_W-1:0] fg_d;
  logic [MANT_W-1:0] fg_f;
  logic              d_bad;
  logic              unused_prod;

  assign prod_val    = bus.product[PROD_HI:PROD_LO];
  // product[47] cannot be set for legal operands; low bits are truncated away
  assign unused_prod = ^{bus.product[PROD_W-1], bus.product[PROD_LO-1:0]};
  assign d_bad       = ~bus.d_in[MANT_W-2] | bus.d_in[MANT_W-1];
  assign iter_inc    = iter_q + IterW'(1);

  // One factor generator serves both the initial seed and the per-iteration update
  assign fg_d = (state_q == StIdle) ? bus.d_in : prod_val;

  gs_factor_gen u_factor (
    .d_i (fg_d),
    .f_o (fg_f)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    f_d     = f_q;
    q_d     = q_q;
    err_d   = err_q;
    iter_d  = iter_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          n_d = bus.n_in;
          d_d = bus.d_in;
          if (d_bad) begin
            state_d = StDone;
            err_d   = 1'b1;
            q_d     = '0;
          end else begin
            state_d = StIssueN;
            f_d     = fg_f;
            iter_d  = '0;
          end
        end
      end
      StIssueN: state_d = StIssueD;
      StIssueD: begin
        state_d = StWait;
        wait_d  = WaitW'(MUL_LAT - 1);
        // With a single-cycle multiplier the N product is already back here
        if (MUL_LAT == 1) n_d = prod_val;
      end
      StWait: begin
        if (wait_q == WaitW'(1)) n_d = prod_val;
        if (wait_q == '0) begin
          d_d    = prod_val;
          iter_d = iter_inc;
          if (iter_inc == IterW'(ITERS)) begin
            state_d = StDone;
            q_d     = n_q;
            err_d   = 1'b0;
          end else begin
            state_d = StIssueN;
            f_d     = fg_f;
          end
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StIdle;
      n_q     <= '0;
      d_q     <= '0;
      f_q     <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
      iter_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      f_q     <= f_d;
      q_q     <= q_d;
      err_q   <= err_d;
      iter_q  <= iter_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs decoded from state; operands are forced to zero outside issue cycles
  always_comb begin
    bus.mul_en = 1'b0;
    bus.mul_a  = '0;
    bus.mul_b  = '0;
    case (state_q)
      StIssueN: begin
        bus.mul_en = 1'b1;
        bus.mul_a  = {8'h00, n_q};
        bus.mul_b  = {8'h00, f_q};
      end
      StIssueD: begin
        bus.mul_en = 1'b1;
        bus.mul_a  = {8'h00, d_q};
        bus.mul_b  = {8'h00, f_q};
      end
      default: ;
    endcase
    bus.busy  = (state_q == StIssueN) || (state_q == StIssueD) || (state_q == StWait);
    bus.done  = (state_q == StDone);
    bus.q_out = q_q;
    bus.err   = err_q;
  end

endmodule

// File: tb/tb_gs_iter_ctrl.sv
// Self-checking bench for gs_iter_ctrl with a behavioural pipelined multiplier.
module tb_gs_iter_ctrl;

  localparam int MulLat = 3;
  localparam int Iters  = 5;
  localparam int DivCyc = 1 + Iters * (MulLat + 2);

  logic clk = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  gs_iter_ctrl_if bus ();

  gs_iter_ctrl #(
    .MUL_LAT (MulLat),
    .ITERS   (Iters)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Multiplier stage: product of an issue appears MulLat cycles later
  logic [47:0] pipe [MulLat];
  always @(posedge clk) begin
    pipe[0] <= bus.mul_en ? 48'(bus.mul_a[23:0]) * 48'(bus.mul_b[23:0]) : 48'h0;
    for (int i = 1; i < MulLat; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.product = pipe[MulLat-1];

  // Reference: Goldschmidt recurrence in plain integer arithmetic
  function automatic void model(input logic [23:0] n, input logic [23:0] d,
                                output logic [23:0] q, output bit e);
    longint unsigned nn, dd, ff;
    if (d[23] || !d[22]) begin
      q = 24'h0;
      e = 1'b1;
      return;
    end
    nn = 64'(n);
    dd = 64'(d);
    for (int i = 0; i < Iters; i++) begin
      ff = (64'h1000000 - dd) & 64'hFFFFFF;
      nn = ((nn * ff) >> 23) & 64'hFFFFFF;
      dd = ((dd * ff) >> 23) & 64'hFFFFFF;
    end
    q = nn[23:0];
    e = 1'b0;
  endfunction

  function automatic longint unsigned lsb_err(input logic [23:0] n, input logic [23:0] d,
                                              input logic [23:0] q);
    longint unsigned exact;
    exact = (64'(n) << 23) / 64'(d);
    return (64'(q) > exact) ? 64'(q) - exact : exact - 64'(q);
  endfunction

  // Results of the most recent run_div
  logic [23:0] r_q, r_a0, r_b0, r_a1, r_b1;
  bit          r_err, r_busy_ok, r_quiet_ok, r_timeout, r_clear_ok, r_busy_at_start;
  int          r_cyc, r_pulses;

  // Drive one start and follow it until done (or clear); cycle 0 is the start cycle
  task automatic run_div(input logic [23:0] n, input logic [23:0] d, input int restart_at,
                         input logic [23:0] n2, input logic [23:0] d2, input int clear_at);
    @(negedge clk);
    r_busy_at_start = bus.busy;
    bus.start = 1'b1;
    bus.n_in  = n;
    bus.d_in  = d;
    r_cyc = 0; r_pulses = 0; r_timeout = 1'b1; r_busy_ok = 1'b1; r_quiet_ok = 1'b1;
    r_clear_ok = 1'b0; r_q = 'x; r_err = 1'bx;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      r_cyc = k;
      if (bus.mul_en) begin
        if (r_pulses == 0) begin r_a0 = bus.mul_a[23:0]; r_b0 = bus.mul_b[23:0]; end
        if (r_pulses == 1) begin r_a1 = bus.mul_a[23:0]; r_b1 = bus.mul_b[23:0]; end
        r_pulses++;
      end else if (bus.mul_a != 32'h0 || bus.mul_b != 32'h0) begin
        r_quiet_ok = 1'b0;
      end
      if (bus.mul_a[31:24] != 8'h0 || bus.mul_b[31:24] != 8'h0) r_quiet_ok = 1'b0;
      if (bus.busy !== !bus.done) r_busy_ok = 1'b0;
      if (bus.done) begin
        r_q = bus.q_out;
        r_err = bus.err;
        r_timeout = 1'b0;
        break;
      end
      if (k == restart_at) begin
        bus.start = 1'b1;
        bus.n_in  = n2;
        bus.d_in  = d2;
      end
      if (k == clear_at) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        r_timeout = 1'b0;
        r_clear_ok = !bus.mul_en && bus.mul_a == 32'h0 && bus.mul_b == 32'h0 && !bus.busy &&
                     !bus.done && bus.q_out == 24'h0 && !bus.err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    bus.start = 1'b0; bus.n_in = 24'h0; bus.d_in = 24'h0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.mul_en, bus.mul_a, bus.mul_b, bus.busy, bus.done, bus.q_out, bus.err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b a=%h b=%h busy=%b done=%b q=%h err=%b, want all 0",
               bus.mul_en, bus.mul_a, bus.mul_b, bus.busy, bus.done, bus.q_out, bus.err);
    end
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mul_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b en=%b, want 0 0 0", bus.busy, bus.done,
               bus.mul_en);
    end
  endtask

  task automatic test_basic();
    logic [23:0] eq; bit ee;
    model(24'h600000, 24'h400000, eq, ee);
    run_div(24'h600000, 24'h400000, -1, 24'h0, 24'h0, -1);
    checks++;
    if (r_timeout || r_cyc != DivCyc) begin
      errors++; $display("FAIL basic_latency: got %0d (timeout=%b) want %0d", r_cyc, r_timeout,
                         DivCyc);
    end
    checks++;
    if (r_q !== eq || r_err !== 1'b0) begin
      errors++; $display("FAIL basic_q: got q=%h err=%b want q=%h err=0", r_q, r_err, eq);
    end
    checks++;
    if (lsb_err(24'h600000, 24'h400000, r_q) > 4 || r_q === 24'hx) begin
      errors++; $display("FAIL basic_accuracy: got %h want within 4 LSB of c00000", r_q);
    end
    checks++;
    if (r_pulses != 2 * Iters) begin
      errors++; $display("FAIL basic_mul_en_count: got %0d want %0d", r_pulses, 2 * Iters);
    end
    checks++;
    if (!r_busy_ok || !r_quiet_ok) begin
      errors++; $display("FAIL basic_busy_operands: busy_ok=%b quiet_ok=%b want 1 1",
                         r_busy_ok, r_quiet_ok);
    end
  endtask

  task automatic test_first_pair();
    logic [23:0] eq; bit ee;
    model(24'h400000, 24'h7FFFFF, eq, ee);
    run_div(24'h400000, 24'h7FFFFF, -1, 24'h0, 24'h0, -1);
    checks++;
    if (r_a0 !== 24'h400000 || r_b0 !== 24'h800001 || r_a1 !== 24'h7FFFFF || r_b1 !== 24'h800001)
    begin
      errors++;
      $display("FAIL first_pair: got %h*%h, %h*%h want 400000*800001, 7fffff*800001",
               r_a0, r_b0, r_a1, r_b1);
    end
    checks++;
    if (r_timeout || r_q !== eq || lsb_err(24'h400000, 24'h7FFFFF, r_q) > 4) begin
      errors++; $display("FAIL first_pair_q: got %h want %h (~400000)", r_q, eq);
    end
  endtask

  task automatic test_err();
    logic [23:0] bad [2];
    bad[0] = 24'h200000;
    bad[1] = 24'h800000;
    for (int i = 0; i < 2; i++) begin
      run_div(24'h600000, bad[i], -1, 24'h0, 24'h0, -1);
      checks++;
      if (r_timeout || r_cyc != 1 || r_err !== 1'b1 || r_q !== 24'h0 || r_pulses != 0) begin
        errors++;
        $display("FAIL err_path d=%h: cyc=%0d err=%b q=%h pulses=%0d want 1 1 000000 0",
                 bad[i], r_cyc, r_err, r_q, r_pulses);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [23:0] eq; bit ee; int extra;
    model(24'h500000, 24'h600000, eq, ee);
    run_div(24'h500000, 24'h600000, 5, 24'h7F0000, 24'h410000, -1);
    extra = 0;
    repeat (DivCyc + 4) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (r_timeout || r_cyc != DivCyc || r_q !== eq) begin
      errors++; $display("FAIL start_ignored_q: got q=%h cyc=%0d want q=%h cyc=%0d", r_q, r_cyc,
                         eq, DivCyc);
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL start_ignored_single_done: got %0d extra active cycles want 0",
                         extra);
    end
  endtask

  task automatic test_clear();
    logic [23:0] eq; bit ee;
    run_div(24'h700000, 24'h500000, -1, 24'h0, 24'h0, 10);
    checks++;
    if (!r_clear_ok) begin
      errors++; $display("FAIL clear_outputs: got nonzero outputs after clear, want all 0");
    end
    model(24'h600000, 24'h400000, eq, ee);
    run_div(24'h600000, 24'h400000, -1, 24'h0, 24'h0, -1);
    checks++;
    if (r_timeout || r_cyc != DivCyc || r_q !== eq || r_err !== 1'b0) begin
      errors++; $display("FAIL clear_restart: got q=%h cyc=%0d err=%b want q=%h cyc=%0d err=0",
                         r_q, r_cyc, r_err, eq, DivCyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] eq; bit ee;
    run_div(24'h480000, 24'h5A0000, -1, 24'h0, 24'h0, -1);
    model(24'h7A0000, 24'h430000, eq, ee);
    run_div(24'h7A0000, 24'h430000, -1, 24'h0, 24'h0, -1);
    checks++;
    if (r_busy_at_start !== 1'b0 || !r_busy_ok) begin
      errors++; $display("FAIL b2b_busy: busy_in_idle=%b busy_ok=%b want 0 1", r_busy_at_start,
                         r_busy_ok);
    end
    checks++;
    if (r_timeout || r_cyc != DivCyc || r_q !== eq) begin
      errors++; $display("FAIL b2b_q: got q=%h cyc=%0d want q=%h cyc=%0d", r_q, r_cyc, eq,
                         DivCyc);
    end
  endtask

  task automatic test_random();
    logic [23:0] n, d, eq; bit ee;
    for (int i = 0; i < 20; i++) begin
      n = 24'h400000 | 24'($urandom() & 32'h3FFFFF);
      d = 24'h400000 | 24'($urandom() & 32'h3FFFFF);
      model(n, d, eq, ee);
      run_div(n, d, -1, 24'h0, 24'h0, -1);
      checks++;
      if (r_timeout || r_q !== eq || r_err !== 1'b0 || r_cyc != DivCyc) begin
        errors++; $display("FAIL random %h/%h: got q=%h err=%b cyc=%0d want q=%h err=0 cyc=%0d",
                           n, d, r_q, r_err, r_cyc, eq, DivCyc);
      end
      checks++;
      if (lsb_err(n, d, r_q) > 4) begin
        errors++; $display("FAIL random_accuracy %h/%h: got %h, error %0d LSB want <= 4", n, d,
                           r_q, lsb_err(n, d, r_q));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_first_pair();
    test_err();
    test_start_ignored();
    test_clear();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gs_iter_ctrl.md
Name: gs_iter_ctrl

Overview:
- Goldschmidt iteration sequencer; sits directly downstream of the pipelined multiplier FIFO stage and closes the loop back into it.
- Accepts normalized numerator/divisor mantissas and issues N*F and D*F multiply pairs to the multiplier stage.
- Captures the 48-bit products, derives the next factor F = 2 - D, and repeats for a fixed iteration count.
- Returns quotient mantissa q = N/D with a start/busy/done handshake.

Parameters:
- MUL_LAT, 3, cycles from mul_en assertion to matching product on product input
- ITERS, 5, number of Goldschmidt multiply pairs per division (>=1)

Ports:
- clk  in  1  clock, rising edge
- clear  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- n_in  in  24  numerator mantissa, Q1.23, required range [0.5,1)
- d_in  in  24  divisor mantissa, Q1.23, required range [0.5,1)
- product  in  48  multiplier result, Q2.46
- mul_a  out  32  multiplier operand A; bits [31:24] always 0
- mul_b  out  32  multiplier operand B; bits [31:24] always 0
- mul_en  out  1  multiply issue strobe (drives multiplier stage rd_en)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, q_out/err valid
- q_out  out  24  quotient mantissa, Q1.23, held until next accepted start
- err  out  1  divisor not normalized (d_in[22]==0 or d_in[23]==1); held with q_out

Behaviour:
- Reset: all outputs 0, state IDLE, internal N/D/F regs 0, iteration count 0. Clear mid-division aborts immediately; no done pulse; in-flight products are ignored.
- Arithmetic: F = 25'h1000000 - D, truncated to 24 bits (valid since D in [0.5,1) gives F in (1,1.5]). Next value = product[46:23] (truncate, no rounding). product[47] is never set for legal inputs and is ignored.
- States:
  - IDLE: start=1 latches n_in/d_in.
    - If the divisor is illegal, go to DONE with err=1, q_out=0, next cycle.
    - Otherwise go to ISSUE_N with F = 2 - d_in, iter=0.
  - ISSUE_N: mul_a=N, mul_b=F, mul_en=1; go to ISSUE_D.
  - ISSUE_D: mul_a=D, mul_b=F, mul_en=1; go to WAIT; load wait counter.
  - WAIT: capture N on the product return MUL_LAT cycles after ISSUE_N, and D on the next cycle.
    - After the D capture, iter+1.
    - If iter==ITERS, go to DONE; else compute F from the new D and go to ISSUE_N the following cycle.
  - DONE: q_out=N, done=1 for one cycle, busy=0; return to IDLE.
- Timing:
  - mul_en is low in every other state; mul_a/mul_b are 0 when mul_en=0.
  - Per iteration: 2 issue cycles + MUL_LAT wait cycles. Total start-to-done = 1 + ITERS*(MUL_LAT+2) cycles (26 at defaults). The err path takes 1 cycle.
- busy:
  - Rises the cycle after an accepted start and falls in the DONE cycle.
  - start while busy is ignored; no queueing.
- Accuracy: for legal inputs and ITERS=5, |q_out - exact N/D| <= 4 LSB (truncation accumulation).

Decomposition:
- Shared package gs_pkg holds:
  - Q-format constants: MANT_W=24, FRAC_W=23, TWO_Q=25'h1000000
  - state enum (IDLE, ISSUE_N, ISSUE_D, WAIT, DONE)
  - product slice indices [46:23]
- One natural sub-module: gs_factor_gen, combinational F = TWO_Q - D with truncation. Keep it separate for reuse by the reciprocal-seed path.
- Everything else stays in the FSM module.

Test Plan:
- n_in=0x600000 (0.75), d_in=0x400000 (0.5), start → done 26 cycles later; q_out within 4 LSB of 0xC00000 (1.5); err=0; exactly 10 mul_en pulses.
- n_in=0x400000, d_in=0x7FFFFF → q_out within 4 LSB of 0x400000. First issued pair is mul_a=0x400000, mul_b=0x800001, then mul_a=0x7FFFFF, mul_b=0x800001.
- d_in=0x200000 (unnormalized), start → done next cycle; err=1, q_out=0, no mul_en.
- start asserted again at cycle 5 of a division → ignored; single done pulse; q_out matches the first operands.
- clear asserted at cycle 10 mid-division → next cycle all outputs 0 and busy=0. A fresh start (0x600000/0x400000) completes correctly in 26 cycles.
- Back-to-back: start in the cycle after done → accepted; second result correct; busy low for exactly the single IDLE cycle between the two divisions.
